// File: rtl/fpu_wb_pkg.sv
// fpu_wb_pkg: shared widths, status flags and queued entry type for the FPU writeback buffer
package fpu_wb_pkg;
   localparam int WIDTH = 16;
   localparam int TAG_WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;
   typedef struct packed {
      logic [WIDTH-1:0]     result;
      status_t              status;
      logic [TAG_WIDTH-1:0] tag;
   } wb_entry_t;
endpackage

// File: rtl/fpu_wb_fifo.sv
// fpu_wb_fifo: entry storage with wrapping pointers, explicit occupancy counter and registered ready
module fpu_wb_fifo
   import fpu_wb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  wb_entry_t        din,
   output wb_entry_t        dout,
   output logic [CNT_W-1:0] count,
   output logic             ready
);
   wb_entry_t mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt_n;
   always_comb cnt_n = flush ? '0 : count + CNT_W'(push) - CNT_W'(pop);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         ready <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         wr_ptr <= flush ? '0 : wr_ptr + PTR_W'(push);
         rd_ptr <= flush ? '0 : rd_ptr + PTR_W'(pop);
         count <= cnt_n;
         ready <= cnt_n != CNT_W'(DEPTH);
         if (push && !flush) mem[wr_ptr] <= din;
      end
   end
   assign dout = mem[rd_ptr];
endmodule

// File: rtl/fpu_wb_buffer.sv
// fpu_wb_buffer: in-order FPU writeback queue with sticky fflags accumulation.
// Define FPU_WB_BYPASS_EN for a zero-latency path when the queue is empty and writeback is ready.
module fpu_wb_buffer
   import fpu_wb_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     result_i,
   input  logic [4:0]           status_i,
   input  logic [TAG_WIDTH-1:0] tag_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [WIDTH-1:0]     result_o,
   output logic [4:0]           status_o,
   output logic [TAG_WIDTH-1:0] tag_o,
   output logic [4:0]           fflags_o,
   input  logic                 fflags_clr_i,
   output logic [CNT_W-1:0]     count_o,
   output logic                 busy_o
);
   wb_entry_t head;
   logic ready_q, push, pop, byp, retire;
   logic [CNT_W-1:0] cnt;
`ifdef FPU_WB_BYPASS_EN
   // ready_q alone gates the bypass so out_ready_i never loops back through in_ready_o
   assign byp = (cnt == '0) && out_ready_i && in_valid_i && ready_q;
   assign in_ready_o = ready_q || (cnt == CNT_W'(DEPTH) && out_ready_i);
`else
   assign byp = 1'b0;
   assign in_ready_o = ready_q;
`endif
   assign out_valid_o = (cnt != '0) || byp;
   assign {result_o, status_o, tag_o} = byp ? {result_i, status_i, tag_i} : head;
   assign push = in_valid_i && in_ready_o;
   assign pop = out_valid_o && out_ready_i;
   assign retire = pop && !flush_i;
   assign count_o = cnt;
   assign busy_o = cnt != '0;
   fpu_wb_fifo u_fifo (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .flush (flush_i),
      .push  (push && !byp),
      .pop   (pop && !byp),
      .din   ({result_i, status_i, tag_i}),
      .dout  (head),
      .count (cnt),
      .ready (ready_q)
   );
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) fflags_o <= '0;
      else fflags_o <= (fflags_clr_i ? 5'b0 : fflags_o) | (retire ? status_o : 5'b0);
   end
   // an upstream producer must not change a refused entry while it keeps it offered
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (in_valid_i && !in_ready_o) |=> (!in_valid_i || $stable({result_i, status_i, tag_i})));
endmodule

// File: tb/tb_fpu_wb_buffer.sv
// tb_fpu_wb_buffer: directed scenarios plus a randomized run against a queue-based reference model
module tb_fpu_wb_buffer;
   logic clk = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0, fflags_clr_i = 1'b0;
   logic [15:0] result_i = '0, result_o;
   logic [4:0] status_i = '0, status_o, fflags_o;
   logic [3:0] tag_i = '0, tag_o;
   logic in_ready_o, out_valid_o, busy_o;
   logic [2:0] count_o;
   int checks = 0, fails = 0;
   typedef struct {logic [15:0] r; logic [4:0] s; logic [3:0] t;} ent_t;
   ent_t q[$];
   logic [4:0] mff;
   logic [15:0] saved [4];
   always #5 clk = ~clk;

   fpu_wb_buffer dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .result_i(result_i), .status_i(status_i), .tag_i(tag_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .result_o(result_o), .status_o(status_o), .tag_o(tag_o), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
      .count_o(count_o), .busy_o(busy_o)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic r, input logic [15:0] res, input logic [4:0] st, input logic [3:0] t);
      in_valid_i = v; out_ready_i = r; result_i = res; status_i = st; tag_i = t;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      drive(0, 0, 0, 0, 0);
      cyc(); cyc();
      checks++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid_o); end
      checks++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b exp 0", in_ready_o); end
      checks++; if (count_o !== 3'd0 || busy_o !== 1'b0) begin fails++; $display("FAIL rst_count got %0d/%b exp 0/0", count_o, busy_o); end
      checks++; if (fflags_o !== 5'd0 || result_o !== 16'd0 || tag_o !== 4'd0) begin fails++; $display("FAIL rst_outputs got %b %h %h exp 0", fflags_o, result_o, tag_o); end
      rst_ni = 1'b1;
      #1;
      checks++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL rel_in_ready_early got %b exp 0", in_ready_o); end
      cyc();
      checks++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL rel_in_ready got %b exp 1", in_ready_o); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         saved[i] = 16'($urandom);
         drive(1, 0, saved[i], 0, 4'(i));
         cyc();
      end
      checks++; if (count_o !== 3'd4) begin fails++; $display("FAIL fill_count got %0d exp 4", count_o); end
      checks++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL fill_ready got %b exp 0", in_ready_o); end
      checks++; if (out_valid_o !== 1'b1 || tag_o !== 4'd0) begin fails++; $display("FAIL fill_head got %b/%0d exp 1/0", out_valid_o, tag_o); end
      drive(1, 0, 16'hBEEF, 0, 4'd9);
      cyc();
      checks++; if (count_o !== 3'd4) begin fails++; $display("FAIL fifth_push count got %0d exp 4", count_o); end
      in_valid_i = 1'b0;
   endtask

   task automatic test_drain();
      drive(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (tag_o !== 4'(i) || result_o !== saved[i]) begin fails++; $display("FAIL drain_order got %0d/%h exp %0d/%h", tag_o, result_o, i, saved[i]); end
         cyc();
      end
      checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL drain_empty got %0d/%b/%b exp 0/0/0", count_o, out_valid_o, busy_o); end
      out_ready_i = 1'b0;
   endtask

   task automatic test_simul_full();
      logic [3:0] exp_tags[$];
      for (int i = 0; i < 4; i++) begin drive(1, 0, 16'(i), 0, 4'(i)); cyc(); end
      drive(1, 1, 16'h0777, 0, 4'd7);
      cyc();
`ifdef FPU_WB_BYPASS_EN
      checks++; if (count_o !== 3'd4) begin fails++; $display("FAIL simul_full_count got %0d exp 4", count_o); end
      exp_tags = '{1, 2, 3, 7};
`else
      checks++; if (count_o !== 3'd3 || in_ready_o !== 1'b1) begin fails++; $display("FAIL pop_full_ready got %0d/%b exp 3/1", count_o, in_ready_o); end
      cyc();
      checks++; if (count_o !== 3'd3) begin fails++; $display("FAIL simul_count got %0d exp 3", count_o); end
      exp_tags = '{2, 3, 7};
`endif
      drive(0, 1, 0, 0, 0);
      foreach (exp_tags[k]) begin
         checks++; if (out_valid_o !== 1'b1 || tag_o !== exp_tags[k]) begin fails++; $display("FAIL simul_order got %b/%0d exp 1/%0d", out_valid_o, tag_o, exp_tags[k]); end
         cyc();
      end
      checks++; if (count_o !== 3'd0) begin fails++; $display("FAIL simul_end got %0d exp 0", count_o); end
      out_ready_i = 1'b0;
   endtask

   task automatic test_fflags();
      drive(1, 0, 16'h1, 5'b00001, 4'd1); cyc();
      drive(1, 0, 16'h2, 5'b10000, 4'd2); cyc();
      drive(0, 1, 0, 0, 0); cyc(); cyc();
      checks++; if (fflags_o !== 5'b10001) begin fails++; $display("FAIL fflags_acc got %b exp 10001", fflags_o); end
      drive(1, 0, 16'h3, 5'b00100, 4'd3); cyc();
      drive(0, 1, 0, 0, 0); fflags_clr_i = 1'b1; cyc();
      fflags_clr_i = 1'b0; out_ready_i = 1'b0;
      checks++; if (fflags_o !== 5'b00100) begin fails++; $display("FAIL fflags_clr_retire got %b exp 00100", fflags_o); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin drive(1, 0, 16'(i), 5'b01000, 4'(i)); cyc(); end
      checks++; if (count_o !== 3'd3) begin fails++; $display("FAIL flush_pre got %0d exp 3", count_o); end
      drive(1, 0, 16'hAAAA, 5'b01000, 4'd5); flush_i = 1'b1; cyc();
      flush_i = 1'b0; in_valid_i = 1'b0;
      checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin fails++; $display("FAIL flush_clear got %0d/%b exp 0/0", count_o, out_valid_o); end
      checks++; if (fflags_o !== 5'b00100 || in_ready_o !== 1'b1) begin fails++; $display("FAIL flush_fflags got %b/%b exp 00100/1", fflags_o, in_ready_o); end
   endtask

`ifdef FPU_WB_BYPASS_EN
   task automatic test_bypass();
      drive(1, 1, 16'h3C00, 5'b00010, 4'd6);
      #1;
      checks++; if (out_valid_o !== 1'b1 || result_o !== 16'h3C00 || tag_o !== 4'd6) begin fails++; $display("FAIL bypass_out got %b/%h/%0d exp 1/3c00/6", out_valid_o, result_o, tag_o); end
      cyc();
      checks++; if (count_o !== 3'd0 || fflags_o !== 5'b00110) begin fails++; $display("FAIL bypass_state got %0d/%b exp 0/00110", count_o, fflags_o); end
      drive(0, 0, 0, 0, 0);
   endtask
`endif

   task automatic test_async_reset();
      for (int i = 0; i < 2; i++) begin drive(1, 0, 16'hF0F0, 5'b11111, 4'hF); cyc(); end
      in_valid_i = 1'b0;
      checks++; if (count_o !== 3'd2) begin fails++; $display("FAIL areset_pre got %0d exp 2", count_o); end
      #2 rst_ni = 1'b0;
      #1;
      checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL areset_now got %0d/%b/%b/%b exp 0/0/0/0", count_o, out_valid_o, in_ready_o, busy_o); end
      checks++; if (result_o !== 16'd0 || tag_o !== 4'd0 || status_o !== 5'd0 || fflags_o !== 5'd0) begin fails++; $display("FAIL areset_data got %h/%h/%b/%b exp 0", result_o, tag_o, status_o, fflags_o); end
      cyc();
      rst_ni = 1'b1;
      cyc();
      checks++; if (in_ready_o !== 1'b1 || count_o !== 3'd0) begin fails++; $display("FAIL areset_release got %b/%0d exp 1/0", in_ready_o, count_o); end
   endtask

   task automatic test_random();
      logic pend, byp, exp_rdy, exp_vld, do_push, do_pop;
      ent_t h, e;
      pend = 1'b0; mff = 5'd0; q.delete();
      for (int n = 0; n < 400; n++) begin
         if (!pend) begin
            in_valid_i = ($urandom_range(0, 3) != 0);
            result_i = 16'($urandom); status_i = 5'($urandom); tag_i = 4'($urandom);
         end
         out_ready_i = ($urandom_range(0, 2) == 0);
         flush_i = ($urandom_range(0, 40) == 0);
         fflags_clr_i = ($urandom_range(0, 20) == 0);
         #1;
         e = '{result_i, status_i, tag_i};
`ifdef FPU_WB_BYPASS_EN
         byp = q.size() == 0 && out_ready_i && in_valid_i;
         exp_rdy = q.size() != 4 || out_ready_i;
`else
         byp = 1'b0;
         exp_rdy = q.size() != 4;
`endif
         exp_vld = q.size() != 0 || byp;
         h = byp ? e : (q.size() != 0 ? q[0] : e);
         checks++; if (in_ready_o !== exp_rdy || out_valid_o !== exp_vld) begin fails++; $display("FAIL rnd_hs cyc %0d got %b/%b exp %b/%b", n, in_ready_o, out_valid_o, exp_rdy, exp_vld); end
         checks++; if (count_o !== 3'(q.size()) || fflags_o !== mff) begin fails++; $display("FAIL rnd_state cyc %0d got %0d/%b exp %0d/%b", n, count_o, fflags_o, q.size(), mff); end
         if (exp_vld) begin
            checks++; if (result_o !== h.r || status_o !== h.s || tag_o !== h.t) begin fails++; $display("FAIL rnd_head cyc %0d got %h/%b/%h exp %h/%b/%h", n, result_o, status_o, tag_o, h.r, h.s, h.t); end
         end
         do_push = in_valid_i && exp_rdy;
         do_pop = exp_vld && out_ready_i;
         mff = (fflags_clr_i ? 5'd0 : mff) | ((do_pop && !flush_i) ? h.s : 5'd0);
         if (flush_i) q.delete();
         else begin
            if (do_pop && !byp) void'(q.pop_front());
            if (do_push && !byp) q.push_back(e);
         end
         pend = in_valid_i && !exp_rdy;
         cyc();
      end
      drive(0, 0, 0, 0, 0); flush_i = 1'b0; fflags_clr_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_simul_full();
      test_fflags();
      test_flush();
`ifdef FPU_WB_BYPASS_EN
      test_bypass();
`endif
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
